// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO; frames go out back-to-back, LSB first,
// timed by the shared baud oversample strobe s_tick.
module uart_tx_fifo #(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_AW    = 2,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int NB_STOP    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               s_tick,
    input  logic [NB_DATA-1:0] din,
    input  logic               wr_en,
    output logic               full,
    output logic               empty,
    output logic               tx_busy,
    output logic               tx_done_tick,
    output logic               overflow_tick,
    output logic               tx
);
    // state  | meaning
    // IDLE   | line high, waiting for a queued byte
    // START  | start bit (low) for SB_TICK ticks
    // DATA   | NB_DATA data bits, LSB first
    // PARITY | optional parity bit over the original byte
    // STOP   | NB_STOP stop bits (high), then done pulse
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int  DEPTH      = 2 ** FIFO_AW;
    localparam int  STOP_TICKS = NB_STOP * SB_TICK;
    localparam int  TW         = $clog2(STOP_TICKS + 1);
    localparam int  BW         = $clog2(NB_DATA + 1);
    localparam bit  ODD        = (PARITY_ODD != 0);

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_n;
    logic               push, pop;

    state_t             state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [NB_DATA-1:0] shift, shift_n;
    logic [NB_DATA-1:0] data, data_n;
    logic               tx_n, done_n;

    assign push    = wr_en && !full;
    assign tx_busy = (state != IDLE);

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // full/empty are registered from the next count so they line up with the pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow_tick <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count         <= count_n;
            full          <= (count_n == (FIFO_AW+1)'(DEPTH));
            empty         <= (count_n == '0);
            overflow_tick <= wr_en && full;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            data         <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shift        <= shift_n;
            data         <= data_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = data;
        pop     = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    data_n  = mem[rd_ptr];
                    tick_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == TW'(SB_TICK - 1)) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == TW'(SB_TICK - 1)) begin
                        tick_n  = '0;
                        shift_n = shift >> 1;
                        if (bit_cnt == BW'(NB_DATA - 1))
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            bit_n = bit_cnt + 1'b1;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_cnt == TW'(SB_TICK - 1)) begin
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == TW'(STOP_TICKS - 1)) begin
                        tick_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = (^data_n) ^ ODD;
            default: tx_n = 1'b1;
        endcase
    end

endmodule
